// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - EX/MEM request, MEM/WB result and data-memory port bundle for mem_access_unit
interface mem_access_unit_if #(
    parameter int ADDR_W = 12
);
    logic              ex_valid;
    logic              ex_ready;
    logic              ex_memread;
    logic              ex_memwrite;
    logic [2:0]        ex_funct3;
    logic [63:0]       ex_addr;
    logic [63:0]       ex_wdata;
    logic [4:0]        ex_rd;

    logic              wb_valid;
    logic [63:0]       wb_rdata;
    logic [4:0]        wb_rd;
    logic              wb_misalign;

    logic              dm_en;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [3:0]        dm_wstrb;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;

    // slave is the sequencer's view; master is the pipeline plus data memory around it
    modport slave (
        input  ex_valid, ex_memread, ex_memwrite, ex_funct3, ex_addr, ex_wdata, ex_rd,
        output ex_ready,
        output wb_valid, wb_rdata, wb_rd, wb_misalign,
        output dm_en, dm_we, dm_addr, dm_wstrb, dm_wdata,
        input  dm_rdata
    );

    modport master (
        output ex_valid, ex_memread, ex_memwrite, ex_funct3, ex_addr, ex_wdata, ex_rd,
        input  ex_ready,
        input  wb_valid, wb_rdata, wb_rd, wb_misalign,
        input  dm_en, dm_we, dm_addr, dm_wstrb, dm_wdata,
        output dm_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV64 load/store sequencer onto a 32-bit word data memory (option: MEM_ACCESS_MISALIGN_TRAP_EN)
module mem_access_unit #(
    parameter int ADDR_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_ISSUE1,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t state, state_d;

    logic              ex_ready_q;
    logic              dm_en_q,    dm_en_d;
    logic              dm_we_q,    dm_we_d;
    logic [ADDR_W-1:0] dm_addr_q,  dm_addr_d;
    logic [3:0]        dm_wstrb_q, dm_wstrb_d;
    logic [31:0]       dm_wdata_q, dm_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [63:0]       wb_rdata_q, wb_rdata_d;
    logic [4:0]        wb_rd_q;

    logic              r_store;
    logic [2:0]        r_funct3;
    logic [1:0]        r_lane;
    logic [ADDR_W-1:0] r_w0;
    logic [31:0]       r_wdata_lo;
    logic [31:0]       r_hi;

    logic              accept;
    logic              in_noacc;
    logic              trap;
    logic [2:0]        align_mask;
    logic [2:0]        in_off;
    logic [ADDR_W-1:0] in_w0;
    logic [3:0]        in_strb;
    logic [31:0]       in_word0;

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [63:0]       ld_value;

    logic              unused_addr_bits;

    assign accept   = bus.ex_valid && ex_ready_q;
    assign in_noacc = (bus.ex_funct3 == 3'b111) || !(bus.ex_memread || bus.ex_memwrite);

    // bits of the byte offset that a naturally aligned access of this size may keep
    always_comb begin
        case (bus.ex_funct3[1:0])
            2'd0:    align_mask = 3'b111;
            2'd1:    align_mask = 3'b110;
            2'd2:    align_mask = 3'b100;
            default: align_mask = 3'b000;
        endcase
    end

    assign in_off = bus.ex_addr[2:0] & align_mask;
    assign in_w0  = {bus.ex_addr[ADDR_W+1:3], in_off[2]};

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign trap = !in_noacc && (bus.ex_addr[2:0] != in_off);
`else
    assign trap = 1'b0;
`endif

    assign unused_addr_bits = ^bus.ex_addr[63:ADDR_W+2];

    always_comb begin
        in_strb  = 4'hF;
        in_word0 = bus.ex_wdata[31:0];
        case (bus.ex_funct3[1:0])
            2'd0: begin
                in_strb  = 4'b0001 << in_off[1:0];
                in_word0 = {4{bus.ex_wdata[7:0]}};
            end
            2'd1: begin
                in_strb  = in_off[1] ? 4'b1100 : 4'b0011;
                in_word0 = {2{bus.ex_wdata[15:0]}};
            end
            2'd2: begin
                in_word0 = bus.ex_wdata[31:0];
            end
            default: begin
                in_word0 = bus.ex_wdata[63:32];
            end
        endcase
    end

    always_comb begin
        ld_byte = bus.dm_rdata[{r_lane, 3'b000} +: 8];
        ld_half = r_lane[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
        case (r_funct3)
            3'b000:  ld_value = {{56{ld_byte[7]}}, ld_byte};
            3'b001:  ld_value = {{48{ld_half[15]}}, ld_half};
            3'b010:  ld_value = {{32{bus.dm_rdata[31]}}, bus.dm_rdata};
            3'b011:  ld_value = {r_hi, bus.dm_rdata};
            3'b100:  ld_value = {56'd0, ld_byte};
            3'b101:  ld_value = {48'd0, ld_half};
            3'b110:  ld_value = {32'd0, bus.dm_rdata};
            default: ld_value = 64'd0;
        endcase
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic wb_misalign_q, wb_misalign_d;
`endif

    // next state plus the next value of every registered output
    always_comb begin
        state_d    = state;
        dm_en_d    = 1'b0;
        dm_we_d    = 1'b0;
        dm_addr_d  = dm_addr_q;
        dm_wstrb_d = 4'd0;
        dm_wdata_d = dm_wdata_q;
        wb_valid_d = 1'b0;
        wb_rdata_d = wb_rdata_q;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        wb_misalign_d = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_noacc || trap) begin
                        state_d    = S_RESP;
                        wb_valid_d = 1'b1;
                        wb_rdata_d = 64'd0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                        wb_misalign_d = trap;
`endif
                    end else begin
                        state_d    = S_ISSUE0;
                        dm_en_d    = 1'b1;
                        dm_we_d    = bus.ex_memwrite;
                        dm_addr_d  = in_w0;
                        dm_wstrb_d = bus.ex_memwrite ? in_strb : 4'd0;
                        dm_wdata_d = in_word0;
                    end
                end
            end
            S_ISSUE0: begin
                if (r_funct3[1:0] == 2'd3) begin
                    state_d    = S_ISSUE1;
                    dm_en_d    = 1'b1;
                    dm_we_d    = r_store;
                    dm_addr_d  = r_w0 + ADDR_W'(1);
                    dm_wstrb_d = r_store ? 4'hF : 4'd0;
                    dm_wdata_d = r_wdata_lo;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_ISSUE1: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d    = S_RESP;
                wb_valid_d = 1'b1;
                wb_rdata_d = r_store ? 64'd0 : ld_value;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ready_q <= 1'b1;
            dm_en_q    <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wstrb_q <= 4'd0;
            dm_wdata_q <= 32'd0;
            wb_valid_q <= 1'b0;
            wb_rdata_q <= 64'd0;
            wb_rd_q    <= 5'd0;
            r_store    <= 1'b0;
            r_funct3   <= 3'd0;
            r_lane     <= 2'd0;
            r_w0       <= '0;
            r_wdata_lo <= 32'd0;
            r_hi       <= 32'd0;
        end else begin
            ex_ready_q <= (state_d == S_IDLE);
            dm_en_q    <= dm_en_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wstrb_q <= dm_wstrb_d;
            dm_wdata_q <= dm_wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_rdata_q <= wb_rdata_d;
            if (accept) begin
                r_store    <= bus.ex_memwrite;
                r_funct3   <= bus.ex_funct3;
                r_lane     <= in_off[1:0];
                r_w0       <= in_w0;
                r_wdata_lo <= bus.ex_wdata[31:0];
                wb_rd_q    <= bus.ex_rd;
            end
            // first word of a doubleword arrives while the second is being issued
            if (state == S_ISSUE1) begin
                r_hi <= bus.dm_rdata;
            end
        end
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_misalign_q <= 1'b0;
        end else begin
            wb_misalign_q <= wb_misalign_d;
        end
    end

    assign bus.wb_misalign = wb_misalign_q;
`else
    assign bus.wb_misalign = 1'b0;
`endif

    assign bus.ex_ready = ex_ready_q;
    assign bus.dm_en    = dm_en_q;
    assign bus.dm_we    = dm_we_q;
    assign bus.dm_addr  = dm_addr_q;
    assign bus.dm_wstrb = dm_wstrb_q;
    assign bus.dm_wdata = dm_wdata_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_rdata = wb_rdata_q;
    assign bus.wb_rd    = wb_rd_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;
    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();
    mem_access_unit #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;

    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    // synchronous data memory: read word appears the cycle after the strobe
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.dm_en) begin
            if (bus.dm_we) begin
                for (int i = 0; i < 4; i++)
                    if (bus.dm_wstrb[i]) mem[bus.dm_addr][8*i +: 8] <= bus.dm_wdata[8*i +: 8];
            end else begin
                bus.dm_rdata <= mem[bus.dm_addr];
            end
        end
    end

    int          o_lat, o_nacc, o_rdy_busy;
    logic [63:0] o_rdata;
    logic        o_mis;
    logic [4:0]  o_rd;
    time         o_t_acc;
    logic [11:0] tr_addr  [0:1];
    logic [31:0] tr_wdata [0:1];
    logic [3:0]  tr_strb  [0:1];
    logic        tr_we    [0:1];
    int          tr_k     [0:1];

    task automatic preload(input logic [11:0] w, input logic [31:0] data);
        pl_en = 1'b1; pl_addr = w; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[w] = data;
    endtask

    // issue one request (called at a negedge) and record everything seen until wb_valid
    task automatic do_op(input bit st, input bit ld, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] d, input logic [4:0] rd);
        int guard;
        bus.ex_valid = 1'b1; bus.ex_memwrite = st; bus.ex_memread = ld;
        bus.ex_funct3 = f3; bus.ex_addr = a; bus.ex_wdata = d; bus.ex_rd = rd;
        guard = 0;
        while (!bus.ex_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        o_t_acc = $time;
        o_lat = 0; o_nacc = 0; o_rdy_busy = 0; o_rdata = '0; o_mis = 1'b0; o_rd = '0;
        for (int i = 0; i < 2; i++) begin
            tr_addr[i] = '0; tr_wdata[i] = '0; tr_strb[i] = '0; tr_we[i] = 1'b0; tr_k[i] = 0;
        end
        for (int k = 1; k <= 20 && o_lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.ex_valid = 1'b0;
                bus.ex_addr = {$urandom, $urandom}; bus.ex_wdata = {$urandom, $urandom};
                bus.ex_rd = 5'($urandom); bus.ex_funct3 = 3'($urandom);
            end
            if (bus.ex_ready) o_rdy_busy++;
            if (bus.dm_en) begin
                if (o_nacc < 2) begin
                    tr_addr[o_nacc] = bus.dm_addr; tr_wdata[o_nacc] = bus.dm_wdata;
                    tr_strb[o_nacc] = bus.dm_wstrb; tr_we[o_nacc] = bus.dm_we; tr_k[o_nacc] = k;
                end
                o_nacc++;
            end
            if (bus.wb_valid) begin
                o_lat = k; o_rdata = bus.wb_rdata; o_mis = bus.wb_misalign; o_rd = bus.wb_rd;
            end
        end
    endtask

    // reference: byte-lane arithmetic over a word array, straight from the load/store rules
    task automatic model(input bit st, input bit ld, input logic [2:0] f3, input logic [63:0] a_in,
                         input logic [63:0] d, output logic [63:0] rdata, output bit mis,
                         output int lat, output int nacc);
        logic [63:0] a, v, mask;
        logic [11:0] w0;
        int nb, k, bits;
        a = a_in; nb = 1 << f3[1:0];
        rdata = '0; mis = 1'b0; lat = 1; nacc = 0;
        if (f3 == 3'b111 || !(st || ld)) return;
        if ((a % nb) != 0) begin
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            mis = 1'b1;
            return;
`else
            a = a - (a % nb);
`endif
        end
        w0 = a[13:2]; k = int'(a[1:0]);
        lat = (nb == 8) ? 4 : 3; nacc = (nb == 8) ? 2 : 1;
        if (st) begin
            if (nb == 8) begin
                ref_mem[w0] = d[63:32]; ref_mem[w0 + 12'd1] = d[31:0];
            end else begin
                for (int i = 0; i < nb; i++) ref_mem[w0][8*(k+i) +: 8] = d[8*i +: 8];
            end
        end else if (nb == 8) begin
            rdata = {ref_mem[w0], ref_mem[w0 + 12'd1]};
        end else begin
            bits = 8 * nb;
            mask = (64'd1 << bits) - 64'd1;
            v = ({32'd0, ref_mem[w0]} >> (8 * k)) & mask;
            if (!f3[2] && v[bits-1]) v = v | ~mask;
            rdata = v;
        end
    endtask

    task automatic test_reset();
        bus.ex_valid = 1'b0; bus.ex_memread = 1'b0; bus.ex_memwrite = 1'b0; bus.ex_funct3 = '0;
        bus.ex_addr = '0; bus.ex_wdata = '0; bus.ex_rd = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready: got %b expected 1", bus.ex_ready); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", bus.wb_valid); end
        checks++; if ({bus.dm_en, bus.dm_we, bus.dm_wstrb} !== 6'd0) begin errors++; $display("FAIL reset_dm_ctrl: got %b expected 0", {bus.dm_en, bus.dm_we, bus.dm_wstrb}); end
        checks++; if ({bus.wb_rdata, bus.wb_rd, bus.wb_misalign} !== 70'd0) begin errors++; $display("FAIL reset_wb_data: got %h expected 0", {bus.wb_rdata, bus.wb_rd, bus.wb_misalign}); end
        checks++; if ({bus.dm_addr, bus.dm_wdata} !== 44'd0) begin errors++; $display("FAIL reset_dm_data: got %h expected 0", {bus.dm_addr, bus.dm_wdata}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sd();
        do_op(1'b1, 1'b0, 3'b011, 64'h100, 64'h1122334455667788, 5'd3);
        checks++; if ({tr_addr[0], tr_wdata[0], tr_strb[0], tr_we[0]} !== {12'h040, 32'h11223344, 4'hF, 1'b1}) begin errors++; $display("FAIL sd_word0: got %h/%h/%h/%b expected 040/11223344/f/1", tr_addr[0], tr_wdata[0], tr_strb[0], tr_we[0]); end
        checks++; if ({tr_addr[1], tr_wdata[1], tr_strb[1], tr_we[1]} !== {12'h041, 32'h55667788, 4'hF, 1'b1}) begin errors++; $display("FAIL sd_word1: got %h/%h/%h/%b expected 041/55667788/f/1", tr_addr[1], tr_wdata[1], tr_strb[1], tr_we[1]); end
        checks++; if (tr_k[0] != 1 || tr_k[1] != 2) begin errors++; $display("FAIL sd_issue_cycles: got %0d,%0d expected 1,2", tr_k[0], tr_k[1]); end
        checks++; if (o_lat != 4 || o_rdata !== 64'd0) begin errors++; $display("FAIL sd_resp: got lat=%0d rdata=%h expected lat=4 rdata=0", o_lat, o_rdata); end
    endtask

    task automatic test_ld();
        do_op(1'b0, 1'b1, 3'b011, 64'h100, 64'h0, 5'd17);
        checks++; if (o_rdata !== 64'h1122334455667788) begin errors++; $display("FAIL ld_rdata: got %h expected 1122334455667788", o_rdata); end
        checks++; if (o_lat != 4 || o_nacc != 2) begin errors++; $display("FAIL ld_timing: got lat=%0d acc=%0d expected 4,2", o_lat, o_nacc); end
        checks++; if (o_rd !== 5'd17) begin errors++; $display("FAIL ld_rd: got %0d expected 17", o_rd); end
    endtask

    task automatic test_lb();
        preload(12'h040, 32'h80FF0000);
        do_op(1'b0, 1'b1, 3'b000, 64'h103, 64'h0, 5'd5);
        checks++; if (o_rdata !== 64'hFFFFFFFFFFFFFF80 || o_lat != 3) begin errors++; $display("FAIL lb_signed: got %h lat=%0d expected ffffffffffffff80 lat=3", o_rdata, o_lat); end
        do_op(1'b0, 1'b1, 3'b100, 64'h103, 64'h0, 5'd6);
        checks++; if (o_rdata !== 64'h80 || o_lat != 3) begin errors++; $display("FAIL lbu_zero: got %h lat=%0d expected 80 lat=3", o_rdata, o_lat); end
    endtask

    task automatic test_sh();
        do_op(1'b1, 1'b0, 3'b001, 64'h102, 64'hABCD, 5'd7);
        checks++; if ({tr_addr[0], tr_wdata[0], tr_strb[0]} !== {12'h040, 32'hABCDABCD, 4'b1100}) begin errors++; $display("FAIL sh_lanes: got %h/%h/%b expected 040/abcdabcd/1100", tr_addr[0], tr_wdata[0], tr_strb[0]); end
        checks++; if (mem[12'h040] !== 32'hABCD0000) begin errors++; $display("FAIL sh_memory: got %h expected abcd0000", mem[12'h040]); end
    endtask

    task automatic test_misalign();
        preload(12'h040, 32'h87654321);
        do_op(1'b0, 1'b1, 3'b010, 64'h102, 64'h0, 5'd9);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        checks++; if (o_lat != 1 || o_mis !== 1'b1 || o_nacc != 0) begin errors++; $display("FAIL lw_trap: got lat=%0d mis=%b acc=%0d expected 1,1,0", o_lat, o_mis, o_nacc); end
        checks++; if (o_rdata !== 64'd0) begin errors++; $display("FAIL lw_trap_rdata: got %h expected 0", o_rdata); end
`else
        checks++; if (o_lat != 3 || o_mis !== 1'b0 || tr_addr[0] !== 12'h040) begin errors++; $display("FAIL lw_forced: got lat=%0d mis=%b addr=%h expected 3,0,040", o_lat, o_mis, tr_addr[0]); end
        checks++; if (o_rdata !== 64'hFFFFFFFF87654321) begin errors++; $display("FAIL lw_forced_rdata: got %h expected ffffffff87654321", o_rdata); end
`endif
    endtask

    task automatic test_back_to_back();
        time t1;
        do_op(1'b0, 1'b1, 3'b010, 64'h100, 64'h0, 5'd1);
        t1 = o_t_acc;
        do_op(1'b0, 1'b1, 3'b011, 64'h100, 64'h0, 5'd2);
        checks++; if (o_t_acc - t1 != 40) begin errors++; $display("FAIL b2b_word_spacing: got %0t expected 40", o_t_acc - t1); end
        t1 = o_t_acc;
        do_op(1'b1, 1'b0, 3'b010, 64'h108, 64'h5A5A5A5A, 5'd3);
        checks++; if (o_t_acc - t1 != 50) begin errors++; $display("FAIL b2b_dword_spacing: got %0t expected 50", o_t_acc - t1); end
    endtask

    task automatic test_random();
        logic [63:0] a, d, e_rdata;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [11:0] w;
        bit          st, ld, e_mis;
        int          e_lat, e_nacc, kind;
        for (int idx = 0; idx < 64; idx++) preload(12'hFE0 + 12'(idx), $urandom);
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            st = (kind >= 6) || (kind == 1);
            ld = (kind >= 2 && kind <= 5) || (kind == 1);
            f3 = 3'($urandom_range(0, 7));
            w = 12'hFE0 + 12'($urandom_range(0, 63));
            a = {$urandom, $urandom}; a[13:2] = w;
            d = {$urandom, $urandom}; rd = 5'($urandom);
            model(st, ld, f3, a, d, e_rdata, e_mis, e_lat, e_nacc);
            do_op(st, ld, f3, a, d, rd);
            checks++; if (o_lat != e_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, o_lat, e_lat); end
            checks++; if (o_rdata !== e_rdata) begin errors++; $display("FAIL rnd%0d_rdata: got %h expected %h", n, o_rdata, e_rdata); end
            checks++; if (o_mis !== e_mis || o_rd !== rd) begin errors++; $display("FAIL rnd%0d_mis_rd: got %b/%0d expected %b/%0d", n, o_mis, o_rd, e_mis, rd); end
            checks++; if (o_nacc != e_nacc || o_rdy_busy != 0) begin errors++; $display("FAIL rnd%0d_access: got acc=%0d ready_busy=%0d expected acc=%0d ready_busy=0", n, o_nacc, o_rdy_busy, e_nacc); end
            @(negedge clk);
            checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_pulse: got wb_valid=%b expected 0", n, bus.wb_valid); end
        end
        for (int idx = 0; idx < 64; idx++) begin
            w = 12'hFE0 + 12'(idx);
            checks++; if (mem[w] !== ref_mem[w]) begin errors++; $display("FAIL rnd_mem_%h: got %h expected %h", w, mem[w], ref_mem[w]); end
        end
    endtask

    task automatic test_reset_midop();
        int guard;
        bit seen;
        bus.ex_valid = 1'b1; bus.ex_memread = 1'b1; bus.ex_memwrite = 1'b0;
        bus.ex_funct3 = 3'b011; bus.ex_addr = 64'h100; bus.ex_rd = 5'd9;
        guard = 0;
        while (!bus.ex_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.dm_en !== 1'b1 || bus.dm_addr !== 12'h041) begin errors++; $display("FAIL midop_issue1: got en=%b addr=%h expected 1/041", bus.dm_en, bus.dm_addr); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({bus.ex_ready, bus.wb_valid, bus.dm_en} !== 3'b100) begin errors++; $display("FAIL midop_reset_state: got %b expected 100", {bus.ex_ready, bus.wb_valid, bus.dm_en}); end
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); if (bus.wb_valid) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL midop_no_resp: got wb_valid=1 expected 0"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sd();
        test_ld();
        test_lb();
        test_sh();
        test_misalign();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
